// File: rtl/unit_ctrl_mc_if.sv
// Signal bundle between the multicycle ARM control unit (master) and the datapath (slave).
// The control unit reads the instruction/ALU flags and drives every mux select and enable.
interface unit_ctrl_mc_if #(
  parameter int unsigned ALUCTRL_W = 3
);
  logic [19:0]          Instr;
  logic [3:0]           ALUFlags;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemWrite;
  logic                 IRWrite;
  logic [1:0]           ResultSrc;
  logic                 ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ImmSrc;
  logic [1:0]           RegSrc;
  logic                 RegWrite;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic [3:0]           Flags;
  logic [3:0]           state_o;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegSrc, RegWrite, ALUControl, Flags, state_o
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegSrc, RegWrite, ALUControl, Flags, state_o
  );
endinterface

// File: rtl/unit_ctrl_mc.sv
// Multicycle ARM control unit: Moore FSM sequencing fetch/decode/execute, condition check,
// architectural NZCV register and configurable memory wait states in FETCH and MEMRD.
module unit_ctrl_mc #(
  parameter int unsigned MEM_LAT   = 0,
  parameter int unsigned ALUCTRL_W = 3
) (
  input  logic           clk,
  input  logic           reset,
  unit_ctrl_mc_if.master bus
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_e;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluAnd = 2'b10;
  localparam logic [1:0] AluOrr = 2'b11;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] flags_q, flags_d;
  logic       wb_en_q, wb_en_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic       i_bit;
  logic [3:0] cmd;
  logic       s_bit;
  logic       cond_ex;
  logic [1:0] dp_op;
  logic       cmd_ok;
  logic       last_wait;

  logic       pc_write, mem_write, ir_write, reg_write;
  logic       adr_src, alu_src_a;
  logic [1:0] result_src, alu_src_b, alu_op;

  assign cond      = bus.Instr[19:16];
  assign op        = bus.Instr[15:14];
  assign i_bit     = bus.Instr[13];
  assign cmd       = bus.Instr[12:9];
  assign s_bit     = bus.Instr[8];
  assign last_wait = (cnt_q == 4'(MEM_LAT));

  // Condition evaluated against the architectural flags, not the live ALU flags.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    dp_op  = AluAdd;
    cmd_ok = 1'b1;
    case (cmd)
      4'b0100: dp_op = AluAdd;
      4'b0010: dp_op = AluSub;
      4'b0000: dp_op = AluAnd;
      4'b1100: dp_op = AluOrr;
      default: begin
        dp_op  = AluAdd;
        cmd_ok = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flags_d    = flags_q;
    wb_en_d    = wb_en_q;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = AluAdd;

    unique case (state_q)
      StFetch: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (last_wait) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          cnt_d    = '0;
          state_d  = StDecode;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDecode: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (op)
          2'b00:   state_d = i_bit ? StExecI : StExecR;
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        alu_src_b = 2'b01;
        state_d   = s_bit ? StMemRd : StMemWr;
      end
      StMemRd: begin
        adr_src = 1'b1;
        if (last_wait) begin
          cnt_d   = '0;
          state_d = StMemWb;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = cond_ex;
        state_d    = StFetch;
      end
      StMemWr: begin
        adr_src   = 1'b1;
        mem_write = cond_ex;
        state_d   = StFetch;
      end
      StExecR, StExecI: begin
        alu_src_b = (state_q == StExecI) ? 2'b01 : 2'b00;
        alu_op    = dp_op;
        // Latch the write-back decision here: ALUWB sees flags already updated by an S op.
        wb_en_d   = cond_ex & cmd_ok;
        if (s_bit && cond_ex && cmd_ok) begin
          flags_d[3:2] = bus.ALUFlags[3:2];
          if (dp_op == AluAdd || dp_op == AluSub) begin
            flags_d[1:0] = bus.ALUFlags[1:0];
          end
        end
        state_d = StAluWb;
      end
      StAluWb: begin
        result_src = 2'b00;
        reg_write  = wb_en_q;
        state_d    = StFetch;
      end
      StBranch: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = cond_ex;
        state_d    = StFetch;
      end
      default: begin
        state_d = StFetch;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      flags_q <= '0;
      wb_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      wb_en_q <= wb_en_d;
    end
  end

  // Enables are masked by reset so nothing is written while it is held low.
  assign bus.PCWrite    = pc_write & reset;
  assign bus.MemWrite   = mem_write & reset;
  assign bus.IRWrite    = ir_write & reset;
  assign bus.RegWrite   = reg_write & reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUControl = ALUCTRL_W'(alu_op);
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {(op == 2'b01), (op == 2'b10)};
  assign bus.Flags      = flags_q;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_unit_ctrl_mc.sv
// Scoreboard bench for unit_ctrl_mc: per-cycle state/enable expectations are queued per
// instruction and compared as the FSM walks through them; flags are checked inline.
module tb_unit_ctrl_mc;

  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst3 = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [3:0] st;
    logic [3:0] en;   // {PCWrite, MemWrite, IRWrite, RegWrite}
    logic [2:0] alu;
    bit         ca;   // compare ALUControl in this cycle
  } exp_t;

  exp_t exp_q[$];

  unit_ctrl_mc_if #(.ALUCTRL_W(3)) if0 ();
  unit_ctrl_mc_if #(.ALUCTRL_W(3)) if3 ();

  unit_ctrl_mc #(.MEM_LAT(0), .ALUCTRL_W(3)) dut0 (
    .clk   (clk),
    .reset (rst0),
    .bus   (if0.master)
  );

  unit_ctrl_mc #(.MEM_LAT(3), .ALUCTRL_W(3)) dut3 (
    .clk   (clk),
    .reset (rst3),
    .bus   (if3.master)
  );

  always #5 clk = ~clk;

  task automatic ex(input logic [3:0] st, input logic [3:0] en, input logic [2:0] alu,
                    input bit ca);
    exp_t e;
    e.st  = st;
    e.en  = en;
    e.alu = alu;
    e.ca  = ca;
    exp_q.push_back(e);
  endtask

  task automatic push_fetch(input int unsigned lat);
    for (int i = 0; i < int'(lat); i++) ex(4'd0, 4'b0000, 3'd0, 1'b0);
    ex(4'd0, 4'b1010, 3'd0, 1'b0);
    ex(4'd1, 4'b0000, 3'd0, 1'b0);
  endtask

  // Drive one instruction word and consume the queued expectations cycle by cycle.
  task automatic run(input string tag, input bit sel, input logic [31:0] word,
                     input logic [3:0] af);
    exp_t       e;
    logic [3:0] st;
    logic [3:0] en;
    logic [2:0] alu;
    int         cyc;
    cyc = 0;
    if (sel) begin
      if3.Instr    = word[31:12];
      if3.ALUFlags = af;
    end else begin
      if0.Instr    = word[31:12];
      if0.ALUFlags = af;
    end
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      st  = sel ? if3.state_o : if0.state_o;
      en  = sel ? {if3.PCWrite, if3.MemWrite, if3.IRWrite, if3.RegWrite}
                : {if0.PCWrite, if0.MemWrite, if0.IRWrite, if0.RegWrite};
      alu = sel ? if3.ALUControl : if0.ALUControl;
      n_vec++;
      if ({st, en} !== {e.st, e.en} || (e.ca && alu !== e.alu)) begin
        n_err++;
        $display("FAIL %s cyc%0d: state/en/alu got %0d/%b/%b want %0d/%b/%b", tag, cyc,
                 st, en, alu, e.st, e.en, e.alu);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    if0.Instr = '0; if0.ALUFlags = '0;
    if3.Instr = '0; if3.ALUFlags = '0;
    rst0 = 1'b0;
    rst3 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({if0.state_o, if0.Flags, if0.PCWrite, if0.MemWrite, if0.IRWrite, if0.RegWrite}
        !== 12'h000) begin
      n_err++;
      $display("FAIL reset0: state/flags/en got %0d/%b/%b%b%b%b want 0/0000/0000",
               if0.state_o, if0.Flags, if0.PCWrite, if0.MemWrite, if0.IRWrite, if0.RegWrite);
    end
    n_vec++;
    if ({if3.state_o, if3.Flags, if3.PCWrite, if3.IRWrite} !== 10'h000) begin
      n_err++;
      $display("FAIL reset3: state/flags got %0d/%b want 0/0000", if3.state_o, if3.Flags);
    end
    @(posedge clk);
    #1;
    rst0 = 1'b1;
  endtask

  task automatic check_flags(input string tag, input bit sel, input logic [3:0] want);
    logic [3:0] got;
    got = sel ? if3.Flags : if0.Flags;
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s flags: got %b want %b", tag, got, want);
    end
  endtask

  task automatic test_dp_imm();
    push_fetch(0);
    ex(4'd7, 4'b0000, 3'b000, 1'b1);
    ex(4'd8, 4'b0001, 3'd0, 1'b0);
    run("add_imm", 1'b0, 32'hE2821005, 4'b1111);
    check_flags("add_nos", 1'b0, 4'b0000);
  endtask

  task automatic test_subs_beq();
    push_fetch(0);
    ex(4'd6, 4'b0000, 3'b001, 1'b1);
    ex(4'd8, 4'b0001, 3'd0, 1'b0);
    run("subs", 1'b0, 32'hE0500000, 4'b0100);
    check_flags("subs", 1'b0, 4'b0100);
    push_fetch(0);
    ex(4'd9, 4'b1000, 3'b000, 1'b1);
    run("beq_taken", 1'b0, 32'h0A000000, 4'b0000);
  endtask

  task automatic test_cond_fail();
    push_fetch(0);
    ex(4'd7, 4'b0000, 3'b000, 1'b1);
    ex(4'd8, 4'b0001, 3'd0, 1'b0);
    run("adds_clr", 1'b0, 32'hE2900001, 4'b0000);
    check_flags("adds_clr", 1'b0, 4'b0000);
    push_fetch(0);
    ex(4'd2, 4'b0000, 3'd0, 1'b0);
    ex(4'd5, 4'b0000, 3'd0, 1'b0);
    run("streq_skip", 1'b0, 32'h05800000, 4'b0000);
    push_fetch(0);
    ex(4'd9, 4'b0000, 3'd0, 1'b0);
    run("beq_skip", 1'b0, 32'h0A000000, 4'b0000);
    push_fetch(0);
    ex(4'd2, 4'b0000, 3'd0, 1'b0);
    ex(4'd5, 4'b0100, 3'd0, 1'b0);
    run("str_al", 1'b0, 32'hE5800000, 4'b0000);
  endtask

  task automatic test_ldr();
    push_fetch(0);
    ex(4'd2, 4'b0000, 3'd0, 1'b0);
    ex(4'd3, 4'b0000, 3'd0, 1'b0);
    ex(4'd4, 4'b0001, 3'd0, 1'b0);
    run("ldr_al", 1'b0, 32'hE5900000, 4'b0000);
  endtask

  task automatic test_flags();
    push_fetch(0);
    ex(4'd6, 4'b0000, 3'b000, 1'b1);
    ex(4'd8, 4'b0001, 3'd0, 1'b0);
    run("adds_ovf", 1'b0, 32'hE0900000, 4'b1001);
    check_flags("adds_ovf", 1'b0, 4'b1001);
    push_fetch(0);
    ex(4'd6, 4'b0000, 3'b010, 1'b1);
    ex(4'd8, 4'b0001, 3'd0, 1'b0);
    run("ands", 1'b0, 32'hE0100000, 4'b0111);
    check_flags("ands_keep_cv", 1'b0, 4'b0101);
    push_fetch(0);
    ex(4'd6, 4'b0000, 3'b011, 1'b1);
    ex(4'd8, 4'b0001, 3'd0, 1'b0);
    run("orrs", 1'b0, 32'hE1900000, 4'b1000);
    check_flags("orrs", 1'b0, 4'b1001);
    push_fetch(0);
    ex(4'd6, 4'b0000, 3'b000, 1'b1);
    ex(4'd8, 4'b0000, 3'd0, 1'b0);
    run("eors_unsup", 1'b0, 32'hE0300000, 4'b1111);
    check_flags("eors_unsup", 1'b0, 4'b1001);
    push_fetch(0);
    ex(4'd6, 4'b0000, 3'b000, 1'b1);
    ex(4'd8, 4'b0000, 3'd0, 1'b0);
    run("addseq_skip", 1'b0, 32'h00900000, 4'b0100);
    check_flags("addseq_skip", 1'b0, 4'b1001);
    push_fetch(0);
    ex(4'd6, 4'b0000, 3'd0, 1'b0);
    ex(4'd8, 4'b0001, 3'd0, 1'b0);
    run("addge", 1'b0, 32'hA0800000, 4'b0000);
    push_fetch(0);
    ex(4'd6, 4'b0000, 3'd0, 1'b0);
    ex(4'd8, 4'b0000, 3'd0, 1'b0);
    run("addlt", 1'b0, 32'hB0800000, 4'b0000);
  endtask

  task automatic test_undef();
    push_fetch(0);
    run("undef", 1'b0, 32'hEC000000, 4'b0000);
    n_vec++;
    if (if0.state_o !== 4'd0 || if0.Flags !== 4'b1001) begin
      n_err++;
      $display("FAIL undef_ret: state/flags got %0d/%b want 0/1001", if0.state_o, if0.Flags);
    end
  endtask

  task automatic test_mem_lat();
    rst3 = 1'b1;
    push_fetch(3);
    ex(4'd2, 4'b0000, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) ex(4'd3, 4'b0000, 3'd0, 1'b0);
    ex(4'd4, 4'b0001, 3'd0, 1'b0);
    run("ldr_lat3", 1'b1, 32'hE5900000, 4'b0000);
    push_fetch(3);
    ex(4'd7, 4'b0000, 3'b000, 1'b1);
    ex(4'd8, 4'b0001, 3'd0, 1'b0);
    run("adds_lat3", 1'b1, 32'hE2900001, 4'b1000);
    check_flags("adds_lat3", 1'b1, 4'b1000);
  endtask

  task automatic test_reset_mid();
    push_fetch(3);
    ex(4'd2, 4'b0000, 3'd0, 1'b0);
    ex(4'd3, 4'b0000, 3'd0, 1'b0);
    ex(4'd3, 4'b0000, 3'd0, 1'b0);
    run("ldr_part", 1'b1, 32'hE5900000, 4'b0000);
    #2;
    rst3 = 1'b0;
    #1;
    n_vec++;
    if ({if3.state_o, if3.Flags, if3.PCWrite, if3.MemWrite, if3.IRWrite, if3.RegWrite}
        !== 12'h000) begin
      n_err++;
      $display("FAIL reset_mid: state/flags/en got %0d/%b/%b%b%b%b want 0/0000/0000",
               if3.state_o, if3.Flags, if3.PCWrite, if3.MemWrite, if3.IRWrite, if3.RegWrite);
    end
    @(posedge clk);
    #1;
    rst3 = 1'b1;
    push_fetch(3);
    run("after_reset", 1'b1, 32'hE5900000, 4'b0000);
  endtask

  initial begin
    test_reset();
    test_dp_imm();
    test_subs_beq();
    test_cond_fail();
    test_ldr();
    test_flags();
    test_undef();
    test_mem_lat();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
